// File: rtl/if_id_queue_pkg.sv
// if_id_queue shared defines: bus widths, zero word and reset level.
// Reset is active-low; RstEnable is the asserted level.
package if_id_queue_pkg;

  localparam logic        RstEnable   = 1'b0;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side valid/ready push channel into the IF/ID queue.
// master = fetch unit, slave = queue.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int AW = InstAddrBus,
  parameter int DW = InstBus
);

  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic          if_ready;

  modport master (
    output if_valid,
    output if_pc,
    output if_inst,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output if_ready
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// IF/ID queue storage: DEPTH x W flops, one write port,
// asynchronous read port. No reset; contents only read when valid.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue with registered ID-side output.
// Define IF_ID_QUEUE_BYPASS_EN for empty-queue fall-through.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = InstAddrBus,
  parameter int DW    = InstBus
) (
  input  logic                       clk,
  input  logic                       rst,
  if_id_queue_if.slave               fetch,
  input  logic                       id_stall,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [AW-1:0]              id_pc,
  output logic [DW-1:0]              id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = AW + DW;
  localparam logic [CW-1:0] Full   = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [PW-1:0] PtrOne = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          pop;
  logic          byp;
  logic          wr_en;
  logic [EW-1:0] head;

  assign fetch.if_ready = (count != Full);
  assign empty = (count == '0);
  assign push  = fetch.if_valid && fetch.if_ready && !flush;
  assign pop   = !id_stall && !empty && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp = empty && fetch.if_valid && !id_stall && !flush;
`else
  assign byp = 1'b0;
`endif

  // a bypassed push goes straight to the output register
  assign wr_en = push && !byp;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({fetch.if_pc, fetch.if_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PtrOne;
      if (pop)   rd_ptr <= rd_ptr + PtrOne;
      case ({wr_en, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (!id_stall) begin
      unique case (1'b1)
        !empty: begin
          id_valid         <= 1'b1;
          {id_pc, id_inst} <= head;
        end
        byp: begin
          id_valid <= 1'b1;
          id_pc    <= fetch.if_pc;
          id_inst  <= fetch.if_inst;
        end
        default: begin
          id_valid <= 1'b0;
          id_pc    <= '0;
          id_inst  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed cases plus an
// in-order scoreboard of accepted pushes vs. ID-side output.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam int L = 1;
`else
  localparam int L = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_stall = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic [CW-1:0] count;

  if_id_queue_if #(.AW(AW), .DW(DW)) fif ();

  if_id_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch    (fif),
    .id_stall (id_stall),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb [$];
  logic        mon_adv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'h0000_0013 ^ (pc << 8);
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    fif.if_valid = v;
    fif.if_pc    = pc;
    fif.if_inst  = mk(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // scoreboard: push on accepted handshake, pop on each new ID load
  always @(posedge clk) begin
    if (!rst) begin
      sb.delete();
      mon_adv = 1'b0;
    end else if (flush) begin
      sb.delete();
      mon_adv = 1'b0;
    end else begin
      if (fif.if_valid && fif.if_ready)
        sb.push_back({fif.if_pc, fif.if_inst});
      mon_adv = !id_stall;
    end
    #1;
    if (mon_adv && id_valid) begin
      if (sb.size() == 0) chk("sb_unexpected", 64'(sb.size()), 64'd1);
      else chk("sb_order", {id_pc, id_inst}, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    drive(1'b0, 32'h0);
    repeat (2) tick;
    chk("rst_valid", id_valid, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_inst", id_inst, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", fif.if_ready, 1);
    rst = 1'b1;
    tick;

    for (int i = 1; i <= 6; i++) begin
      if (i <= 3) drive(1'b1, 32'((i - 1) * 4));
      else drive(1'b0, 32'h0);
      tick;
      chk("stream_cnt", 64'(count <= 1), 1);
      if (i >= L && i <= L + 2) begin
        chk("stream_v", id_valid, 1);
        chk("stream_pc", id_pc, 64'((i - L) * 4));
      end else begin
        chk("stream_idle", id_valid, 0);
      end
    end

    id_stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4));
      if (fif.if_ready) acc++;
      tick;
      chk("fill_frozen", id_valid, 0);
    end
    drive(1'b0, 32'h0);
    chk("fill_acc", 64'(acc), 4);
    chk("fill_ready", fif.if_ready, 0);
    chk("fill_count", count, 4);
    chk("fill_pc", id_pc, 0);
    id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("drain_v", id_valid, 1);
      chk("drain_pc", id_pc, 64'(32'h100 + 32'(i * 4)));
    end
    tick;
    chk("drain_bubble", id_valid, 0);

    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4));
      tick;
    end
    chk("full_count", count, 4);
    id_stall = 1'b0;
    drive(1'b1, 32'h210);
    tick;
    chk("fullpop_count", count, 3);
    chk("fullpop_pc", id_pc, 32'h200);
    chk("fullpop_ready", fif.if_ready, 1);
    tick;
    chk("pushpop_count", count, 3);
    chk("pushpop_pc", id_pc, 32'h204);
    drive(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("full_drain_pc", id_pc, 64'(32'h208 + 32'(i * 4)));
    end
    tick;
    chk("full_bubble", id_valid, 0);

    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4));
      tick;
    end
    drive(1'b0, 32'h0);
    id_stall = 1'b0;
    tick;
    id_stall = 1'b1;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", id_valid, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", id_valid, 0);
    chk("arst_pc", id_pc, 0);
    chk("arst_inst", id_inst, 0);
    chk("arst_count", count, 0);
    tick;
    rst = 1'b1;
    id_stall = 1'b0;
    tick;
    chk("post_rst_valid", id_valid, 0);

    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4));
      tick;
    end
    drive(1'b0, 32'h0);
    id_stall = 1'b0;
    tick;
    chk("pre_flush_count", count, 2);
    chk("pre_flush_valid", id_valid, 1);
    id_stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h4f0);
    tick;
    chk("flush_count", count, 0);
    chk("flush_valid", id_valid, 0);
    flush = 1'b0;
    id_stall = 1'b0;
    drive(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("flush_gone", id_valid, 0);
    end

    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 32'h500 + 32'(r * 32'h100));
      tick;
      drive(1'b0, 32'h0);
      n = 1;
      while (!id_valid && n < 5) begin
        tick;
        n++;
      end
      chk("lat_edges", id_valid ? 64'(n) : 64'd0, 64'(L));
      chk("lat_pc", id_pc, 64'(32'h500 + 32'(r * 32'h100)));
      repeat (3) tick;
    end

    chk("sb_drain", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
